// File: rtl/if_pc_gen_if.sv
// Fetch-PC bus between the hazard/EX side (master) and if_pc_gen (slave).
interface if_pc_gen_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        if_flush;
  logic [31:0] fetch_count;
  logic        misalign_trap;

  modport master (
    output stall, redirect, redirect_target,
    input  pc, pc_plus4, if_valid, if_flush, fetch_count, misalign_trap
  );

  modport slave (
    input  stall, redirect, redirect_target,
    output pc, pc_plus4, if_valid, if_flush, fetch_count, misalign_trap
  );
endinterface

// File: rtl/if_pc_gen.sv
// IF-stage program-counter generator: BOOT/RUN/HALT sequencing, redirect/stall priority.
// Optional macro PC_MISALIGN_TRAP_EN halts on a misaligned redirect target instead of masking it.
module if_pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  if_pc_gen_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_p0;
  logic [31:0] pc_p0;
  logic [31:0] fetch_count_p0;

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_p0;
`endif

  // ---- fetch state / PC register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0       <= BOOT;
      pc_p0          <= RESET_VECTOR;
      fetch_count_p0 <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_p0        <= 1'b0;
`endif
    end else begin
      case (state_p0)
        BOOT: state_p0 <= RUN;
        RUN: begin
          if (bus.redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (bus.redirect_target[1:0] != 2'b00) begin
              state_p0 <= HALT;
              trap_p0  <= 1'b1;
            end else begin
              pc_p0 <= {bus.redirect_target[31:2], 2'b00};
            end
`else
            pc_p0 <= bus.redirect_target & ~32'd3;
`endif
          end else if (!bus.stall) begin
            pc_p0          <= pc_p0 + 32'd4;
            fetch_count_p0 <= fetch_count_p0 + 32'd1;
          end
        end
        HALT:    state_p0 <= HALT;
        default: state_p0 <= BOOT;
      endcase
    end
  end

  // ---- combinational outputs; redirect reaches valid/flush in the same cycle ----
  assign bus.pc          = pc_p0;
  assign bus.pc_plus4    = pc_p0 + 32'd4;
  assign bus.fetch_count = fetch_count_p0;
  assign bus.if_valid    = (state_p0 == RUN) && !bus.redirect;
  assign bus.if_flush    = ((state_p0 == RUN) && bus.redirect) || (state_p0 == HALT);

`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_trap = trap_p0;
`else
  assign bus.misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: directed scenarios plus randomized traffic against a spec-level model.
module tb_if_pc_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  if_pc_gen_if bus ();

  if_pc_gen #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec-level model: fetch PC, accepted-instruction count, and phase flags.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_booted;
  bit          m_halted;
  bit          m_trap;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic bit exp_valid();
    return m_booted && !m_halted && !bus.redirect;
  endfunction

  function automatic bit exp_flush();
    return m_halted || (m_booted && bus.redirect);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = 32'h0; m_booted = 0; m_halted = 0; m_trap = 0;
  endtask

  task automatic drive(input bit s, input bit r, input logic [31:0] t);
    bus.stall = s; bus.redirect = r; bus.redirect_target = t;
    #1;
  endtask

  // Advance one rising edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!m_booted) m_booted = 1;
    else if (!m_halted) begin
      if (bus.redirect) begin
        if (TRAP_EN && bus.redirect_target[1:0] != 2'b00) begin
          m_halted = 1; m_trap = 1;
        end else begin
          m_pc = {bus.redirect_target[31:2], 2'b00};
        end
      end else if (!bus.stall) begin
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 32'h100);
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h0); end
    n_checks++; if (bus.fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.fetch_count); end
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.if_valid); end
    n_checks++; if (bus.if_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", bus.if_flush); end
    n_checks++; if (bus.misalign_trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %b want 0", bus.misalign_trap); end
    @(posedge clk); #1;
    rst = 1'b0;
    // BOOT cycle: redirect must be ignored.
    drive(1'b0, 1'b1, 32'h100);
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", bus.if_valid); end
    n_checks++; if (bus.if_flush !== 1'b0) begin n_fail++; $display("FAIL boot_flush got %b want 0", bus.if_flush); end
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL boot_pc got %h want 0", bus.pc); end
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL boot_exit_pc got %h want 0", bus.pc); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      n_checks++; if (bus.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc, 32'(4 * i)); end
      n_checks++; if (bus.fetch_count !== 32'(i)) begin n_fail++; $display("FAIL seq_cnt[%0d] got %0d want %0d", i, bus.fetch_count, i); end
      n_checks++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.if_valid); end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      n_checks++; if (bus.if_flush !== 1'b0) begin n_fail++; $display("FAIL stall_flush[%0d] got %b want 0", i, bus.if_flush); end
      tick();
      n_checks++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 10", i, bus.pc); end
      n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d want 4", i, bus.fetch_count); end
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL stall_release_pc got %h want 14", bus.pc); end
    tick();
    tick();
  endtask

  task automatic test_redirect();
    logic [31:0] cnt_before;
    cnt_before = m_cnt;
    n_checks++; if (bus.pc !== 32'h1C) begin n_fail++; $display("FAIL redir_start_pc got %h want 1c", bus.pc); end
    drive(1'b0, 1'b1, 32'h40);
    n_checks++; if (bus.if_flush !== 1'b1) begin n_fail++; $display("FAIL redir_flush got %b want 1", bus.if_flush); end
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", bus.if_valid); end
    tick();
    n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc got %h want 40", bus.pc); end
    n_checks++; if (bus.fetch_count !== cnt_before) begin n_fail++; $display("FAIL redir_cnt got %0d want %0d", bus.fetch_count, cnt_before); end
    drive(1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_after_valid got %b want 1", bus.if_valid); end
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, 1'b1, 32'h80);
    n_checks++; if (bus.if_flush !== 1'b1) begin n_fail++; $display("FAIL rs_flush got %b want 1", bus.if_flush); end
    tick();
    n_checks++; if (bus.pc !== 32'h80) begin n_fail++; $display("FAIL rs_pc got %h want 80", bus.pc); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h want fffffffc", bus.pc); end
    n_checks++; if (bus.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got %h want 0", bus.pc_plus4); end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", bus.pc); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    bit s, r;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 4) == 0);
      t = $urandom();
      if (TRAP_EN) t[1:0] = 2'b00;
      drive(s, r, t);
      n_checks++; if (bus.if_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.if_valid, exp_valid()); end
      n_checks++; if (bus.if_flush !== exp_flush()) begin n_fail++; $display("FAIL rnd_flush[%0d] got %b want %b", i, bus.if_flush, exp_flush()); end
      tick();
      n_checks++; if (bus.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.pc, m_pc); end
      n_checks++; if (bus.pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_plus4[%0d] got %h want %h", i, bus.pc_plus4, m_pc + 32'd4); end
      n_checks++; if (bus.fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, bus.fetch_count, m_cnt); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] pc_before, cnt_before;
    drive(1'b0, 1'b1, 32'h40);
    tick();
    pc_before = m_pc; cnt_before = m_cnt;
    drive(1'b0, 1'b1, 32'h42);
    n_checks++; if (bus.if_flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush got %b want 1", bus.if_flush); end
    tick();
    if (TRAP_EN) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, 1'b0, 32'h0);
        n_checks++; if (bus.pc !== pc_before) begin n_fail++; $display("FAIL halt_pc[%0d] got %h want %h", i, bus.pc, pc_before); end
        n_checks++; if (bus.misalign_trap !== 1'b1) begin n_fail++; $display("FAIL halt_trap[%0d] got %b want 1", i, bus.misalign_trap); end
        n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d] got %b want 0", i, bus.if_valid); end
        n_checks++; if (bus.if_flush !== 1'b1) begin n_fail++; $display("FAIL halt_flush[%0d] got %b want 1", i, bus.if_flush); end
        n_checks++; if (bus.fetch_count !== cnt_before) begin n_fail++; $display("FAIL halt_cnt[%0d] got %0d want %0d", i, bus.fetch_count, cnt_before); end
        tick();
      end
    end else begin
      n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL mis_pc got %h want 40", bus.pc); end
      n_checks++; if (bus.misalign_trap !== 1'b0) begin n_fail++; $display("FAIL mis_trap got %b want 0", bus.misalign_trap); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 32'h200);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc got %h want 0", bus.pc); end
    n_checks++; if (bus.fetch_count !== 32'h0) begin n_fail++; $display("FAIL arst_cnt got %0d want 0", bus.fetch_count); end
    n_checks++; if (bus.misalign_trap !== 1'b0) begin n_fail++; $display("FAIL arst_trap got %b want 0", bus.misalign_trap); end
    n_checks++; if (bus.if_flush !== 1'b0) begin n_fail++; $display("FAIL arst_flush got %b want 0", bus.if_flush); end
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", bus.if_valid); end
    @(posedge clk); #1;
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL arst_hold_pc got %h want 0", bus.pc); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL arst_resume_pc got %h want 4", bus.pc); end
    n_checks++; if (bus.fetch_count !== 32'd1) begin n_fail++; $display("FAIL arst_resume_cnt got %0d want 1", bus.fetch_count); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_random();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
